// File: rtl/key_event_fifo.sv
// key_event_fifo: turns the 3-column keypad scanner stream into one key code
// per frame, debounces that code over several frames, and queues each press
// event in a small show-ahead FIFO that is popped with rd_en.
// Optional build macro: KEY_REPEAT_EN adds auto-repeat of the held key every
// REPEAT_FRAMES frames. Without it, each press produces exactly one event.
module key_event_fifo #(
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int CNT_W           = 3,
  parameter int REPEAT_FRAMES   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       keyData,
  input  logic [2:0]       columnSel,
  input  logic             rd_en,
  output logic [3:0]       rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             key_held,
  output logic [3:0]       held_code
);

  localparam int         PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [3:0] NO_KEY   = 4'hF;
  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_FRAMES - 1);
  localparam bit CFG_OK = (DEBOUNCE_FRAMES >= 2) && (DEBOUNCE_FRAMES <= 15) &&
                          (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) &&
                          (FIFO_DEPTH < (1 << CNT_W)) && (REPEAT_FRAMES >= 1);

  generate
    if (!CFG_OK) begin : g_cfg_check
      $error("key_event_fifo: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    HELD         = 2'd2,
    RELEASE_PEND = 2'd3
  } deb_state_e;

  // frame accumulator
  logic [3:0]       acc_q, acc_d, acc_now;
  logic             multi_q, multi_d, multi_now;
  logic             frame_end;
  logic [3:0]       frame_res;
  // debounce
  deb_state_e       state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic             key_held_q, key_held_d;
  logic [3:0]       held_code_q, held_code_d;
  logic             push;
  logic [3:0]       push_code;
  // fifo
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [3:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, empty_d, full_q, full_d;
  logic             overflow_q, overflow_d;
  logic [3:0]       rd_data_q, rd_data_d;
  logic             pop, push_ok;

`ifdef KEY_REPEAT_EN
  localparam int           RPT_W    = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_FRAMES - 1);
  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  // Merge the columns of one scan frame; a second distinct code marks the frame as multi-key.
  always_comb begin
    acc_now   = acc_q;
    multi_now = multi_q;
    if (keyData != NO_KEY) begin
      if (acc_q == NO_KEY) begin
        acc_now = keyData;
      end else if (keyData != acc_q) begin
        multi_now = 1'b1;
      end else begin
        multi_now = multi_q;
      end
    end else begin
      acc_now = acc_q;
    end
    frame_end = (columnSel == 3'b100);
    frame_res = multi_now ? NO_KEY : acc_now;
    if (frame_end) begin
      acc_d   = NO_KEY;
      multi_d = 1'b0;
    end else begin
      acc_d   = acc_now;
      multi_d = multi_now;
    end
  end

  // Debounce state machine; it only moves on frame-end cycles and raises push on an accepted press.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    fcnt_d      = fcnt_q;
    key_held_d  = key_held_q;
    held_code_d = held_code_q;
    push        = 1'b0;
    push_code   = cand_q;
`ifdef KEY_REPEAT_EN
    rpt_d       = rpt_q;
`endif
    if (frame_end) begin
      case (state_q)
        RELEASED: begin
          if (frame_res != NO_KEY) begin
            cand_d  = frame_res;
            fcnt_d  = 4'd1;
            state_d = PRESS_PEND;
          end else begin
            state_d = RELEASED;
          end
        end
        PRESS_PEND: begin
          if (frame_res == cand_q) begin
            if (fcnt_q == DEB_LAST) begin
              state_d     = HELD;
              key_held_d  = 1'b1;
              held_code_d = cand_q;
              push        = 1'b1;
              push_code   = cand_q;
`ifdef KEY_REPEAT_EN
              rpt_d       = {RPT_W{1'b0}};
`endif
            end else begin
              fcnt_d = fcnt_q + 4'd1;
            end
          end else if (frame_res == NO_KEY) begin
            state_d = RELEASED;
          end else begin
            cand_d = frame_res;
            fcnt_d = 4'd1;
          end
        end
        HELD: begin
          if (frame_res != held_code_q) begin
            state_d = RELEASE_PEND;
            fcnt_d  = 4'd1;
`ifdef KEY_REPEAT_EN
            rpt_d   = {RPT_W{1'b0}};
`endif
          end else begin
`ifdef KEY_REPEAT_EN
            if (rpt_q == RPT_LAST) begin
              rpt_d     = {RPT_W{1'b0}};
              push      = 1'b1;
              push_code = held_code_q;
            end else begin
              rpt_d = rpt_q + RPT_W'(1'b1);
            end
`else
            state_d = HELD;
`endif
          end
        end
        RELEASE_PEND: begin
          if (frame_res == NO_KEY) begin
            if (fcnt_q == DEB_LAST) begin
              state_d     = RELEASED;
              key_held_d  = 1'b0;
              held_code_d = NO_KEY;
            end else begin
              fcnt_d = fcnt_q + 4'd1;
            end
          end else begin
            // same key back, or a different key: either way the key is not released
            state_d = HELD;
`ifdef KEY_REPEAT_EN
            rpt_d   = {RPT_W{1'b0}};
`endif
          end
        end
        default: begin
          state_d     = RELEASED;
          key_held_d  = 1'b0;
          held_code_d = NO_KEY;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FIFO next state: simultaneous push and pop are both honoured, so a full FIFO can still accept.
  always_comb begin
    pop     = rd_en && !empty_q;
    push_ok = push && (!full_q || pop);
    mem_d   = mem_q;
    if (push_ok) begin
      mem_d[tail_q] = push_code;
      tail_d        = tail_q + PTR_W'(1'b1);
    end else begin
      tail_d = tail_q;
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1'b1);
    end else begin
      head_d = head_q;
    end
    overflow_d = overflow_q || (push && !push_ok);
    count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    empty_d    = (count_d == {CNT_W{1'b0}});
    full_d     = (count_d == CNT_W'(FIFO_DEPTH));
    rd_data_d  = empty_d ? NO_KEY : mem_d[head_d];
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q       <= NO_KEY;
      multi_q     <= 1'b0;
      state_q     <= RELEASED;
      cand_q      <= NO_KEY;
      fcnt_q      <= 4'd0;
      key_held_q  <= 1'b0;
      held_code_q <= NO_KEY;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= NO_KEY;
      end
      head_q      <= {PTR_W{1'b0}};
      tail_q      <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      rd_data_q   <= NO_KEY;
`ifdef KEY_REPEAT_EN
      rpt_q       <= {RPT_W{1'b0}};
`endif
    end else begin
      acc_q       <= acc_d;
      multi_q     <= multi_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      fcnt_q      <= fcnt_d;
      key_held_q  <= key_held_d;
      held_code_q <= held_code_d;
      mem_q       <= mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      rd_data_q   <= rd_data_d;
`ifdef KEY_REPEAT_EN
      rpt_q       <= rpt_d;
`endif
    end
  end

  assign rd_data   = rd_data_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign key_held  = key_held_q;
  assign held_code = held_code_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// Self-checking bench for key_event_fifo: directed scenarios plus randomized
// scan streams compared against a frame-level behavioural model.
module tb_key_event_fifo;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;
  localparam int CNTW  = 3;
  localparam int RPT   = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      keyData;
  logic [2:0]      columnSel;
  logic            rd_en;
  logic [3:0]      rd_data;
  logic            empty;
  logic            full;
  logic [CNTW-1:0] count;
  logic            overflow;
  logic            key_held;
  logic [3:0]      held_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_event_fifo #(
    .DEBOUNCE_FRAMES(DEB), .FIFO_DEPTH(DEPTH), .CNT_W(CNTW), .REPEAT_FRAMES(RPT)
  ) dut (
    .clk(clk), .rst(rst), .keyData(keyData), .columnSel(columnSel), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .key_held(key_held), .held_code(held_code)
  );

  // ---------------- behavioural reference model ----------------
  logic [3:0] m_q[$];      // queued events
  logic [3:0] m_frame[$];  // non-idle codes seen in the current frame
  bit         m_ovf;
  bit         m_held;
  logic [3:0] m_hcode;
  logic [3:0] m_run_code;
  int         m_run_len;   // length of the current run of one code while not held
  int         m_rel_len;   // frames counted toward release while held (0 = none)
  int         m_rpt;

  task automatic model_reset();
    m_q.delete();
    m_frame.delete();
    m_ovf      = 1'b0;
    m_held     = 1'b0;
    m_hcode    = 4'hF;
    m_run_code = 4'hF;
    m_run_len  = 0;
    m_rel_len  = 0;
    m_rpt      = 0;
  endtask

  function automatic logic [3:0] frame_result();
    logic [3:0] r = 4'hF;
    for (int i = 0; i < m_frame.size(); i++) begin
      if (r == 4'hF) r = m_frame[i];
      else if (m_frame[i] != r) return 4'hF;
    end
    return r;
  endfunction

  task automatic model_frame(input logic [3:0] res, output bit push, output logic [3:0] code);
    push = 1'b0;
    code = 4'hF;
    if (!m_held) begin
      if (res == 4'hF) m_run_len = 0;
      else if (m_run_len > 0 && res == m_run_code) m_run_len++;
      else begin m_run_code = res; m_run_len = 1; end
      if (m_run_len == DEB) begin
        push = 1'b1; code = res;
        m_held = 1'b1; m_hcode = res; m_rel_len = 0; m_run_len = 0; m_rpt = 0;
      end
    end else if (m_rel_len == 0) begin
      if (res != m_hcode) begin
        m_rel_len = 1; m_rpt = 0;
      end else begin
`ifdef KEY_REPEAT_EN
        m_rpt++;
        if (m_rpt == RPT) begin push = 1'b1; code = m_hcode; m_rpt = 0; end
`endif
      end
    end else if (res == 4'hF) begin
      m_rel_len++;
      if (m_rel_len == DEB) begin m_held = 1'b0; m_hcode = 4'hF; m_run_len = 0; end
    end else begin
      m_rel_len = 0; m_rpt = 0;
    end
  endtask

  // One clock cycle: drive inputs, take the edge, advance the model, settle.
  task automatic cycle(input logic [3:0] kd, input logic [2:0] cs, input logic rd, input logic rv);
    bit         pop_now;
    bit         push;
    logic [3:0] code;
    keyData = kd; columnSel = cs; rd_en = rd; rst = rv;
    @(posedge clk);
    if (!rv) begin
      model_reset();
    end else begin
      push = 1'b0; code = 4'hF;
      pop_now = rd && (m_q.size() > 0);
      if (kd != 4'hF) m_frame.push_back(kd);
      if (cs == 3'b100) begin
        model_frame(frame_result(), push, code);
        m_frame.delete();
      end
      if (pop_now) m_q.delete(0);
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(code);
        else m_ovf = 1'b1;
      end
    end
    #1;
  endtask

  task automatic frame(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2, input logic rd_last);
    cycle(c0, 3'b001, 1'b0, 1'b1);
    cycle(c1, 3'b010, 1'b0, 1'b1);
    cycle(c2, 3'b100, rd_last, 1'b1);
  endtask

  task automatic frames(input int n, input logic [3:0] code);
    repeat (n) frame(4'hF, code, 4'hF, 1'b0);
  endtask

  task automatic press_release(input logic [3:0] code);
    frames(DEB, code);
    frames(DEB, 4'hF);
  endtask

  task automatic do_reset();
    cycle(4'hF, 3'b001, 1'b0, 1'b0);
    cycle(4'hF, 3'b001, 1'b0, 1'b0);
  endtask

  task automatic pop_one();
    cycle(4'hF, 3'b001, 1'b1, 1'b1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0)      begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (rd_data !== 4'hF)   begin errors++; $display("FAIL reset_rd_data: got %h expected f", rd_data); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (key_held !== 1'b0)  begin errors++; $display("FAIL reset_key_held: got %b expected 0", key_held); end
    checks++; if (held_code !== 4'hF) begin errors++; $display("FAIL reset_held_code: got %h expected f", held_code); end
  endtask

  task automatic test_press();
    do_reset();
    frames(3, 4'h5);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL press_early_empty: got %b expected 1", empty); end
    frames(1, 4'h5);
    checks++; if (empty !== 1'b0)   begin errors++; $display("FAIL press_latency_empty: got %b expected 0", empty); end
    checks++; if (rd_data !== 4'h5) begin errors++; $display("FAIL press_latency_rd: got %h expected 5", rd_data); end
    frames(2, 4'h5);
    checks++; if (count !== 3'd1)     begin errors++; $display("FAIL press_count: got %0d expected 1", count); end
    checks++; if (key_held !== 1'b1)  begin errors++; $display("FAIL press_key_held: got %b expected 1", key_held); end
    checks++; if (held_code !== 4'h5) begin errors++; $display("FAIL press_held_code: got %h expected 5", held_code); end
    frames(DEB - 1, 4'hF);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL release_early: got %b expected 1", key_held); end
    frames(1, 4'hF);
    checks++; if (key_held !== 1'b0)  begin errors++; $display("FAIL release_key_held: got %b expected 0", key_held); end
    checks++; if (held_code !== 4'hF) begin errors++; $display("FAIL release_held_code: got %h expected f", held_code); end
    checks++; if (count !== 3'd1)     begin errors++; $display("FAIL release_no_event: got %0d expected 1", count); end
    pop_one();
    checks++; if (empty !== 1'b1 || rd_data !== 4'hF) begin errors++; $display("FAIL press_pop: got empty=%b rd=%h expected empty=1 rd=f", empty, rd_data); end
    pop_one();
    checks++; if (empty !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL pop_when_empty: got empty=%b count=%0d expected 1/0", empty, count); end
  endtask

  task automatic test_glitch();
    do_reset();
    frames(2, 4'h7);
    frames(DEB, 4'hF);
    checks++; if (count !== 3'd0)    begin errors++; $display("FAIL glitch_count: got %0d expected 0", count); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL glitch_key_held: got %b expected 0", key_held); end
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL glitch_empty: got %b expected 1", empty); end
  endtask

  task automatic test_multi_key();
    do_reset();
    repeat (5) frame(4'h1, 4'h2, 4'hF, 1'b0);
    checks++; if (count !== 3'd0)    begin errors++; $display("FAIL multi_count: got %0d expected 0", count); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multi_key_held: got %b expected 0", key_held); end
    frames(4, 4'h2);
    checks++; if (count !== 3'd1)     begin errors++; $display("FAIL multi_then_single_count: got %0d expected 1", count); end
    checks++; if (rd_data !== 4'h2)   begin errors++; $display("FAIL multi_then_single_rd: got %h expected 2", rd_data); end
    checks++; if (held_code !== 4'h2) begin errors++; $display("FAIL multi_then_single_held: got %h expected 2", held_code); end
  endtask

  task automatic test_overflow();
    logic [3:0] codes [5];
    codes[0] = 4'h1; codes[1] = 4'h2; codes[2] = 4'h3; codes[3] = 4'h4; codes[4] = 4'h6;
    do_reset();
    for (int i = 0; i < 4; i++) press_release(codes[i]);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b expected 0", overflow); end
    press_release(codes[4]);
    checks++; if (full !== 1'b1)     begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
    checks++; if (count !== 3'd4)    begin errors++; $display("FAIL ovf_count: got %0d expected 4", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data !== codes[i]) begin errors++; $display("FAIL ovf_pop%0d: got %h expected %h", i, rd_data, codes[i]); end
      pop_one();
    end
    checks++; if (empty !== 1'b1 || rd_data !== 4'hF) begin errors++; $display("FAIL ovf_drained: got empty=%b rd=%h expected 1/f", empty, rd_data); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_push_pop_full();
    logic [3:0] exp_order [4];
    exp_order[0] = 4'h2; exp_order[1] = 4'h3; exp_order[2] = 4'h4; exp_order[3] = 4'h9;
    do_reset();
    for (int i = 1; i <= 4; i++) press_release(4'(i));
    frames(DEB - 1, 4'h9);
    frame(4'hF, 4'h9, 4'hF, 1'b1);
    checks++; if (count !== 3'd4)    begin errors++; $display("FAIL pp_count: got %0d expected 4", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow: got %b expected 0", overflow); end
    checks++; if (full !== 1'b1)     begin errors++; $display("FAIL pp_full: got %b expected 1", full); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data !== exp_order[i]) begin errors++; $display("FAIL pp_pop%0d: got %h expected %h", i, rd_data, exp_order[i]); end
      pop_one();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_release(4'h1);
    frames(DEB, 4'h3);
    checks++; if (count !== 3'd2 || key_held !== 1'b1) begin errors++; $display("FAIL mid_setup: got count=%0d held=%b expected 2/1", count, key_held); end
    cycle(4'hF, 3'b001, 1'b0, 1'b1);
    cycle(4'h3, 3'b010, 1'b0, 1'b0);
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL mid_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL mid_empty: got %b expected 1", empty); end
    checks++; if (key_held !== 1'b0)  begin errors++; $display("FAIL mid_key_held: got %b expected 0", key_held); end
    checks++; if (held_code !== 4'hF) begin errors++; $display("FAIL mid_held_code: got %h expected f", held_code); end
    frames(DEB - 1, 4'h3);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_rearm_early: got %b expected 1", empty); end
    frames(1, 4'h3);
    checks++; if (empty !== 1'b0 || rd_data !== 4'h3) begin errors++; $display("FAIL mid_rearm: got empty=%b rd=%h expected 0/3", empty, rd_data); end
  endtask

  task automatic test_random();
    logic [3:0] kd [4];
    logic [2:0] cs [4];
    logic [3:0] cols [3];
    logic [3:0] exp_rd;
    int n, mode, nf, col, col2;
    logic [3:0] c1, c2;
    do_reset();
    for (int ep = 0; ep < 300; ep++) begin
      mode = $urandom_range(0, 9);
      c1   = 4'($urandom_range(0, 14));
      c2   = 4'($urandom_range(0, 14));
      col  = $urandom_range(0, 2);
      col2 = (col + 1) % 3;
      nf   = $urandom_range(1, 7);
      for (int f = 0; f < nf; f++) begin
        cols[0] = 4'hF; cols[1] = 4'hF; cols[2] = 4'hF;
        if (mode >= 3) cols[col] = c1;
        if (mode == 9) cols[col2] = c2;
        n = 0;
        if ($urandom_range(0, 7) == 0) begin
          cs[n] = 3'($urandom_range(0, 7));
          if (cs[n] == 3'b100) cs[n] = 3'b001;
          kd[n] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
          n++;
        end
        for (int c = 0; c < 3; c++) begin
          cs[n] = (c == 0) ? 3'b001 : (c == 1) ? 3'b010 : 3'b100;
          kd[n] = cols[c];
          n++;
        end
        for (int k = 0; k < n; k++) begin
          cycle(kd[k], cs[k], ($urandom_range(0, 47) == 0), ($urandom_range(0, 999) != 0));
          exp_rd = (m_q.size() > 0) ? m_q[0] : 4'hF;
          checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL rnd_rd_data ep%0d: got %h expected %h", ep, rd_data, exp_rd); end
          checks++; if (count !== CNTW'(m_q.size())) begin errors++; $display("FAIL rnd_count ep%0d: got %0d expected %0d", ep, count, m_q.size()); end
          checks++; if (empty !== (m_q.size() == 0)) begin errors++; $display("FAIL rnd_empty ep%0d: got %b expected %b", ep, empty, (m_q.size() == 0)); end
          checks++; if (full !== (m_q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full ep%0d: got %b expected %b", ep, full, (m_q.size() == DEPTH)); end
          checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow ep%0d: got %b expected %b", ep, overflow, m_ovf); end
          checks++; if (key_held !== m_held) begin errors++; $display("FAIL rnd_key_held ep%0d: got %b expected %b", ep, key_held, m_held); end
          checks++; if (held_code !== m_hcode) begin errors++; $display("FAIL rnd_held_code ep%0d: got %h expected %h", ep, held_code, m_hcode); end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; keyData = 4'hF; columnSel = 3'b001; rd_en = 1'b0;
    model_reset();
    test_reset();
    test_press();
    test_glitch();
    test_multi_key();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_fifo.md
Name: key_event_fifo

Overview:
Sits directly downstream of the 3-column keypad scanner and consumes its per-column keyData/columnSel outputs. Aggregates each 3-cycle scan frame into one key code, debounces it over several frames, and detects press events. Each press event is queued in a small show-ahead FIFO that the PIC16C57 port logic reads with a simple rd_en pop handshake.

Parameters:
DEBOUNCE_FRAMES, 4, consecutive identical frames needed to accept a new stable key state (range 2..15)
FIFO_DEPTH, 4, number of queued key events; power of 2, at least 2
CNT_W, 3, width of count output; must hold the value FIFO_DEPTH
REPEAT_FRAMES, 32, auto-repeat period in frames; used only when KEY_REPEAT_EN is defined

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-low reset (0 = reset)
keyData  input  4  scanner key code for the current column; 4'hF = no key
columnSel  input  3  scanner column strobe; 3'b100 marks the last column of a frame
rd_en  input  1  pop request; pops the head entry at the clock edge when empty=0
rd_data  output  4  head FIFO entry (show-ahead); 4'hF when empty
empty  output  1  FIFO holds no entries
full  output  1  FIFO holds FIFO_DEPTH entries
count  output  CNT_W  number of entries held
overflow  output  1  sticky; a press event was dropped because the FIFO was full
key_held  output  1  debounced state: a key is currently pressed
held_code  output  4  debounced key code; 4'hF when key_held=0

Behaviour:
- Reset (rst=0 at an edge) is synchronous and applies mid-operation at any time. It clears:
  - FIFO pointers and contents; count=0, empty=1, full=0, rd_data=4'hF
  - overflow=0, key_held=0, held_code=4'hF
  - frame accumulator, multi-key flag, debounce state and counters
- Frame aggregation, every cycle:
  - keyData != 4'hF and accumulator empty: capture keyData.
  - keyData != 4'hF, accumulator non-empty, and value differs: set the multi flag.
  - The frame result is formed combinationally in the cycle where columnSel==3'b100, using that cycle's keyData.
  - Frame result = 4'hF if the multi flag is set (ghost/multi-key rejection), otherwise the single captured code or 4'hF.
  - Accumulator and multi flag clear at that edge.
  - columnSel values other than 3'b100 (including the scanner's idle 3'b001) never end a frame.
- Debounce FSM, states RELEASED, PRESS_PEND, HELD, RELEASE_PEND. It advances only at frame-end edges.
  - cand (4b) holds the candidate code; fcnt (4b) counts identical frames.
  - RELEASED, result != F: cand=result, fcnt=1, go to PRESS_PEND.
  - PRESS_PEND, result == cand: fcnt++.
    - When fcnt reaches DEBOUNCE_FRAMES: go to HELD, key_held=1, held_code=cand, push a press event with code cand (same edge).
  - PRESS_PEND, result differs:
    - result == F: go to RELEASED.
    - result is another code: restart with cand=result, fcnt=1.
  - HELD, result != held_code: fcnt=1, go to RELEASE_PEND.
  - RELEASE_PEND:
    - result == F for DEBOUNCE_FRAMES consecutive frames (counting the entry frame): go to RELEASED, key_held=0, held_code=F.
    - result == held_code: return to HELD.
    - Any other code: the frame counts as "not released" and the state returns to HELD. A new key requires a full release first, so there is no direct key-to-key event.
- Latency: a key steady from frame k is pushed at the frame-end edge of frame k+DEBOUNCE_FRAMES-1. empty drops and rd_data shows the code in the next cycle.
- FIFO:
  - rd_data = mem[head] when empty=0.
  - Pop (rd_en=1 with empty=0) advances head at the edge. rd_en while empty is ignored with no error.
  - Push while full without a pop in the same edge: the event is dropped and overflow is set. overflow stays set until reset.
  - Push and pop at the same edge: both occur and count is unchanged. When full, no overflow is flagged.
  - Pointers wrap modulo FIFO_DEPTH.
  - count, empty and full are registered and consistent after every edge.

Optional Feature:
KEY_REPEAT_EN
- Defined: while in HELD, a repeat counter increments each frame end. Every REPEAT_FRAMES frames it pushes held_code again, following the normal overflow rules. The counter clears on entering HELD or leaving it.
- Undefined: exactly one event per press; no repeat counter logic is present.

Test Plan:
- Hold key 5 for 6 frames (DEBOUNCE_FRAMES=4) -> empty=0 after the 4th frame-end edge; rd_data=4'h5, count=1, key_held=1, held_code=4'h5.
- Key 7 present for only 2 frames, then released -> no push, count=0, key_held=0.
- Keys 1 and 2 in the same frame for 5 frames -> frame result F, no event. Then key 2 alone for 4 frames -> one event, code 2.
- Five debounced presses (codes 1,2,3,4,6) without reads -> full=1, count=4, overflow=1. Pops return 1,2,3,4, then empty=1 and rd_data=F.
- FIFO full with rd_en=1 at the same edge as a push of code 9 -> count stays 4, overflow=0, last entry is 9.
- rst=0 mid-frame while in HELD with 2 entries queued -> next cycle: count=0, empty=1, key_held=0, held_code=F. Key still held afterwards -> a new event after DEBOUNCE_FRAMES frames.
